// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
// Defaults here seed the top-level parameters.
package fetch_pkg;

    localparam int          DEF_PC_WIDTH   = 32;
    localparam int          DEF_INST_WIDTH = 32;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam int          DEF_FIFO_DEPTH = 2;

    // Byte distance between consecutive instruction words.
    localparam int          PC_INCR        = 4;

    localparam logic [0:0]  ST_RUN         = 1'b0;
    localparam logic [0:0]  ST_ERR         = 1'b1;

    typedef enum logic [0:0] {
        RUN = ST_RUN,
        ERR = ST_ERR
    } fetch_state_e;

    function automatic logic pc_is_aligned(input logic [1:0] pc_lsb);
        return (pc_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {instruction, pc} entries with a flush that
// overrides push and pop. Head reads as zero while the FIFO is empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_din,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_rd_en;
    logic w_wr_en;

    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == CW'(DEPTH));
        w_rd_en = i_pop & ~i_flush & ~w_empty;
        // A full FIFO may still accept a write when the head leaves this cycle.
        w_wr_en = i_push & ~i_flush & (~w_full | w_rd_en);
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_wr_en) - CW'(w_rd_en);
        end
    end

    assign o_count = r_count;
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: drives the IMEM address, buffers returned words with their
// PCs and hands them to decode; redirects flush the buffer and trap misalignment.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                         PC_WIDTH_LENGTH   = DEF_PC_WIDTH,
    parameter int                         INST_WIDTH_LENGTH = DEF_INST_WIDTH,
    parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC          = PC_WIDTH_LENGTH'(DEF_RESET_PC),
    parameter int                         FIFO_DEPTH        = DEF_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [PC_WIDTH_LENGTH-1:0]   imem_pc,
    input  logic [INST_WIDTH_LENGTH-1:0] imem_inst,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [INST_WIDTH_LENGTH-1:0] inst,
    output logic [PC_WIDTH_LENGTH-1:0]   inst_pc,
    output logic                         misalign_err
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = INST_WIDTH_LENGTH + PC_WIDTH_LENGTH;

    logic [PC_WIDTH_LENGTH-1:0] r_fetch_pc;
    logic [0:0]                 r_state;
    logic                       r_misalign_err;

    logic [CNT_W-1:0]           w_count;
    logic [ENTRY_W-1:0]         w_head;
    logic [ENTRY_W-1:0]         w_entry;
    logic                       w_run;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_target_ok;

    always_comb begin
        w_run       = (r_state == ST_RUN);
        w_target_ok = pc_is_aligned(redirect_pc[1:0]);
        // A redirect cancels any handshake in the same cycle.
        w_pop       = inst_valid & inst_ready & ~redirect_valid;
        w_push      = w_run & ~redirect_valid &
                      ((w_count < CNT_W'(FIFO_DEPTH)) | w_pop);
        w_entry     = {imem_inst, r_fetch_pc};
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc     <= RESET_PC;
            r_state        <= ST_RUN;
            r_misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            // Misaligned targets are kept in fetch_pc so imem_pc shows the culprit.
            r_fetch_pc     <= redirect_pc;
            r_state        <= w_target_ok ? ST_RUN : ST_ERR;
            r_misalign_err <= ~w_target_ok;
        end else if (w_push) begin
            r_fetch_pc     <= r_fetch_pc + PC_WIDTH_LENGTH'(PC_INCR);
        end
    end

    assign imem_pc      = r_fetch_pc;
    assign inst_valid   = (w_count != '0) & w_run;
    assign inst         = w_head[ENTRY_W-1:PC_WIDTH_LENGTH];
    assign inst_pc      = w_head[PC_WIDTH_LENGTH-1:0];
    assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomised scoreboard bench for imem_fetch_ctrl against a queue-based model.
module tb_imem_fetch_ctrl;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        misalign_err;

    always #5 clk = ~clk;

    // Every address returns a distinct word so mis-paired {inst, pc} is visible.
    function automatic logic [31:0] imem_word(input logic [31:0] pc);
        logic [31:0] k;
        k = pc >> 2;
        return k ^ {pc[9:2], 24'h0};
    endfunction

    assign imem_inst = imem_word(imem_pc);

    imem_fetch_ctrl #(
        .PC_WIDTH_LENGTH   (32),
        .INST_WIDTH_LENGTH (32),
        .RESET_PC          (RST_PC),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misalign_err   (misalign_err)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] ipc;
        logic        err;
        logic [31:0] hpc;
        logic [31:0] hinst;
    } rec_t;

    rec_t        rec_q[$];
    logic [31:0] m_fifo[$];
    logic [31:0] m_fetch = RST_PC;
    bit          m_err   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_fetch = RST_PC;
        m_err   = 1'b0;
    endtask

    // One clock cycle: drive inputs, publish expected outputs for this cycle,
    // then advance the model to what the next edge should produce.
    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc, input bit rs);
        rec_t r;
        bit   pop;
        bit   push;
        @(posedge clk);
        #2;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rs && !rst) begin
            rst = 1'b1;
            #1;
            chk("async_rst_valid", 32'(inst_valid), 32'h0);
            chk("async_rst_imem_pc", imem_pc, RST_PC);
            chk("async_rst_inst", inst, 32'h0);
            chk("async_rst_inst_pc", inst_pc, 32'h0);
            chk("async_rst_misalign", 32'(misalign_err), 32'h0);
        end else begin
            rst = rs;
        end
        if (rs) model_reset();

        r.v     = (m_fifo.size() > 0) && !m_err;
        r.ipc   = m_fetch;
        r.err   = m_err;
        r.hpc   = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
        r.hinst = (m_fifo.size() > 0) ? imem_word(m_fifo[0]) : 32'h0;
        rec_q.push_back(r);

        if (rs) begin
            model_reset();
        end else if (rv) begin
            m_fifo.delete();
            m_fetch = rpc;
            m_err   = (rpc[1:0] != 2'b00);
        end else if (!m_err) begin
            pop  = (m_fifo.size() > 0) && rdy;
            push = (m_fifo.size() < DEPTH) || pop;
            if (pop) void'(m_fifo.pop_front());
            if (push) begin
                m_fifo.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    // Monitor: compares the DUT against the record published for this cycle.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (rec_q.size() > 0) begin
                r = rec_q.pop_front();
                chk("inst_valid", 32'(inst_valid), 32'(r.v));
                chk("imem_pc", imem_pc, r.ipc);
                chk("misalign_err", 32'(misalign_err), 32'(r.err));
                chk("inst_pc", inst_pc, r.hpc);
                chk("inst", inst, r.hinst);
                if (inst_valid && inst_ready && !redirect_valid && !rst)
                    $display("ACCEPT pc=%h inst=%h t=%0t", inst_pc, inst, $time);
            end
        end
    end

    initial begin
        // Reset, then stream with decode always ready.
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Backpressure after a fresh reset, then release.
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Redirect while full with decode ready: nothing accepted that cycle.
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0100, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Misaligned redirect, then recovery through an aligned one.
        cycle(1'b1, 1'b1, 32'h0000_0102, 1'b0);
        repeat (6) cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Address wrap past 0xFFFF_FFFC.
        cycle(1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset with one entry buffered, then restart.
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bit          rdy;
            bit          rv;
            bit          rs;
            logic [31:0] rnd;
            logic [31:0] rpc;
            int          sel;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rs  = ($urandom_range(0, 299) == 0);
            rnd = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 6)
                rpc = {rnd[31:2], 2'b00};
            else if (sel < 8)
                rpc = 32'hFFFF_FFF0 | {28'h0, rnd[3:2], 2'b00};
            else
                rpc = {rnd[31:2], (rnd[1:0] == 2'b00) ? 2'b10 : rnd[1:0]};
            cycle(rdy, rv, rpc, rs);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(rec_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
